// File: rtl/clock_core.sv
// MM:SS BCD timekeeping core with run/pause/adjust FSM and display blink/select decode.
// Optional countdown mode is enabled by defining CLOCK_CORE_COUNTDOWN_EN (adds input count_down).
module clock_core #(
  parameter int MIN_MAX = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       sw_adj,
  input  logic       sw_sel,
`ifdef CLOCK_CORE_COUNTDOWN_EN
  input  logic       count_down,
`endif
  output logic [3:0] mt,
  output logic [3:0] mo,
  output logic [3:0] st,
  output logic [3:0] so,
  output logic       blink_enable,
  output logic       blink_state,
  output logic       sel_minutes,
  output logic       sel_seconds,
  output logic       rollover
);

  typedef enum logic [1:0] {RUN, PAUSE, ADJ} state_t;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } time_t;

  localparam logic [3:0] MT_MAX = 4'(MIN_MAX / 10);
  localparam logic [3:0] MO_MAX = 4'(MIN_MAX % 10);

  state_t state;
  time_t  tm, t_up, t_dn, t_adj;
  logic   prev_pause, prev_clear;
  logic   pause_edge, clear_edge, cd;
  logic   min_max, sec_max, sec_zero, min_zero, up_wrap;
  logic [3:0] mt_inc, mo_inc, st_inc, so_inc;

`ifdef CLOCK_CORE_COUNTDOWN_EN
  assign cd = count_down;
`else
  assign cd = 1'b0;
`endif

  assign pause_edge = btn_pause & ~prev_pause;
  assign clear_edge = btn_clear & ~prev_clear;

  always_comb begin
    min_max  = (tm.mt == MT_MAX) && (tm.mo == MO_MAX);
    sec_max  = (tm.st == 4'd5) && (tm.so == 4'd9);
    sec_zero = (tm.st == 4'd0) && (tm.so == 4'd0);
    min_zero = (tm.mt == 4'd0) && (tm.mo == 4'd0);

    // Field-local increments: each wraps on its own and never carries out.
    mt_inc = tm.mt;
    mo_inc = tm.mo + 4'd1;
    if (min_max) begin
      mt_inc = 4'd0;
      mo_inc = 4'd0;
    end else if (tm.mo == 4'd9) begin
      mt_inc = tm.mt + 4'd1;
      mo_inc = 4'd0;
    end
    st_inc = tm.st;
    so_inc = tm.so + 4'd1;
    if (sec_max) begin
      st_inc = 4'd0;
      so_inc = 4'd0;
    end else if (tm.so == 4'd9) begin
      st_inc = tm.st + 4'd1;
      so_inc = 4'd0;
    end

    t_up    = sec_max ? '{mt_inc, mo_inc, 4'd0, 4'd0} : '{tm.mt, tm.mo, st_inc, so_inc};
    up_wrap = sec_max && min_max;

    t_adj = sw_sel ? '{tm.mt, tm.mo, st_inc, so_inc} : '{mt_inc, mo_inc, tm.st, tm.so};

    // Borrowing decrement; 00:00 stays put and is flagged by the caller.
    t_dn = tm;
    if (!sec_zero) begin
      if (tm.so == 4'd0) begin
        t_dn.st = tm.st - 4'd1;
        t_dn.so = 4'd9;
      end else begin
        t_dn.so = tm.so - 4'd1;
      end
    end else if (!min_zero) begin
      t_dn.st = 4'd5;
      t_dn.so = 4'd9;
      if (tm.mo == 4'd0) begin
        t_dn.mt = tm.mt - 4'd1;
        t_dn.mo = 4'd9;
      end else begin
        t_dn.mo = tm.mo - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tm          <= '0;
      state       <= PAUSE;
      rollover    <= 1'b0;
      blink_state <= 1'b0;
      prev_pause  <= 1'b1;
      prev_clear  <= 1'b1;
    end else begin
      prev_pause <= btn_pause;
      prev_clear <= btn_clear;
      rollover   <= 1'b0;

      if (sw_adj && state != ADJ)
        blink_state <= 1'b1;
      else if (tick_2hz)
        blink_state <= ~blink_state;

      if (sw_adj)
        state <= ADJ;
      else if (state == ADJ)
        state <= PAUSE;
      else if (state == RUN && tick_1hz && cd && sec_zero && min_zero && !clear_edge)
        state <= PAUSE;
      else if (pause_edge)
        state <= (state == RUN) ? PAUSE : RUN;

      // Ticks act on the pre-transition state; clear overrides any tick.
      if (clear_edge) begin
        tm <= '0;
      end else if (state == RUN && tick_1hz) begin
        if (cd) begin
          tm       <= t_dn;
          rollover <= sec_zero && min_zero;
        end else begin
          tm       <= t_up;
          rollover <= up_wrap;
        end
      end else if (state == ADJ && tick_2hz) begin
        tm <= t_adj;
      end
    end
  end

  assign mt           = tm.mt;
  assign mo           = tm.mo;
  assign st           = tm.st;
  assign so           = tm.so;
  assign blink_enable = (state == ADJ);
  assign sel_minutes  = (state == ADJ) && !sw_sel;
  assign sel_seconds  = (state == ADJ) && sw_sel;

endmodule

// File: tb/tb_clock_core.sv
// Scoreboard bench for clock_core: driver runs a time-in-seconds reference model and queues
// expected outputs; a monitor compares them against the DUT one cycle later.
module tb_clock_core;
  localparam int MIN_MAX = 99;

  typedef enum {M_RUN, M_PAUSE, M_ADJ} mstate_t;
  typedef struct packed {
    logic [3:0] mt, mo, st, so;
    logic       roll, blink, ben, selm, sels;
  } obs_t;

  logic clk = 1'b0;
  logic rst, tick_1hz, tick_2hz, btn_pause, btn_clear, sw_adj, sw_sel, count_down;
  logic [3:0] mt, mo, st, so;
  logic blink_enable, blink_state, sel_minutes, sel_seconds, rollover;

  always #5 clk = ~clk;

  clock_core #(.MIN_MAX(MIN_MAX)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .btn_pause(btn_pause), .btn_clear(btn_clear), .sw_adj(sw_adj), .sw_sel(sw_sel),
`ifdef CLOCK_CORE_COUNTDOWN_EN
    .count_down(count_down),
`endif
    .mt(mt), .mo(mo), .st(st), .so(so),
    .blink_enable(blink_enable), .blink_state(blink_state),
    .sel_minutes(sel_minutes), .sel_seconds(sel_seconds), .rollover(rollover)
  );

  obs_t    exp_q[$];
  int      checks = 0;
  int      failures = 0;

  // Reference model state: time kept as plain minutes/seconds integers.
  mstate_t m_st = M_PAUSE;
  int      m_min = 0, m_sec = 0;
  bit      m_roll = 0, m_blink = 0, m_pp = 1, m_pc = 1;

  bit lv_pause = 0, lv_clear = 0, lv_adj = 0, lv_sel = 0, lv_cd = 0;

  function automatic obs_t model_obs();
    obs_t o;
    o.mt    = 4'(m_min / 10);
    o.mo    = 4'(m_min % 10);
    o.st    = 4'(m_sec / 10);
    o.so    = 4'(m_sec % 10);
    o.roll  = m_roll;
    o.blink = m_blink;
    o.ben   = (m_st == M_ADJ);
    o.selm  = (m_st == M_ADJ) && !lv_sel;
    o.sels  = (m_st == M_ADJ) && lv_sel;
    return o;
  endfunction

  task automatic model(input bit r, input bit t1, input bit t2);
    bit pe, ce, cdn;
    int total;
    mstate_t nst;
    cdn = 0;
`ifdef CLOCK_CORE_COUNTDOWN_EN
    cdn = lv_cd;
`endif
    if (r) begin
      m_min = 0; m_sec = 0; m_st = M_PAUSE; m_roll = 0; m_blink = 0; m_pp = 1; m_pc = 1;
      return;
    end
    pe = lv_pause && !m_pp;
    ce = lv_clear && !m_pc;
    m_pp = lv_pause;
    m_pc = lv_clear;
    m_roll = 0;
    if (lv_adj) nst = M_ADJ;
    else if (m_st == M_ADJ) nst = M_PAUSE;
    else if (pe) nst = (m_st == M_RUN) ? M_PAUSE : M_RUN;
    else nst = m_st;
    if (lv_adj && m_st != M_ADJ) m_blink = 1;
    else if (t2) m_blink = !m_blink;
    if (ce) begin
      m_min = 0; m_sec = 0;
    end else if (m_st == M_RUN && t1) begin
      total = m_min * 60 + m_sec;
      if (cdn) begin
        if (total == 0) begin
          m_roll = 1;
          if (!lv_adj) nst = M_PAUSE;
        end else total--;
      end else begin
        total++;
        if (total == (MIN_MAX + 1) * 60) begin
          total = 0;
          m_roll = 1;
        end
      end
      m_min = total / 60;
      m_sec = total % 60;
    end else if (m_st == M_ADJ && t2) begin
      if (lv_sel) m_sec = (m_sec + 1) % 60;
      else        m_min = (m_min + 1) % (MIN_MAX + 1);
    end
    m_st = nst;
  endtask

  task automatic step(input bit r, input bit t1, input bit t2);
    @(negedge clk);
    rst = r; tick_1hz = t1; tick_2hz = t2;
    btn_pause = lv_pause; btn_clear = lv_clear; sw_adj = lv_adj; sw_sel = lv_sel;
    count_down = lv_cd;
    model(r, t1, t2);
    exp_q.push_back(model_obs());
  endtask

  task automatic press_pause();
    lv_pause = 1; step(0, 0, 0);
    lv_pause = 0; step(0, 0, 0);
  endtask

  // Monitor: one comparison per clock, sampled just after the edge.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{mt, mo, st, so, rollover, blink_state, blink_enable, sel_minutes, sel_seconds};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs t=%0t got %h%h:%h%h roll=%b blink=%b ben=%b selm=%b sels=%b, want %h%h:%h%h roll=%b blink=%b ben=%b selm=%b sels=%b",
                   $time, a.mt, a.mo, a.st, a.so, a.roll, a.blink, a.ben, a.selm, a.sels,
                   e.mt, e.mo, e.st, e.so, e.roll, e.blink, e.ben, e.selm, e.sels);
        end
      end
    end
  end

  initial begin
    rst = 1; tick_1hz = 0; tick_2hz = 0; btn_pause = 0; btn_clear = 0;
    sw_adj = 0; sw_sel = 0; count_down = 0;
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);

    // Run and count to 01:15.
    press_pause();
    for (int i = 0; i < 75; i++) begin
      step(0, 1, 0);
      step(0, 0, 0);
    end

    // Preload 99:58 through ADJ, then run across the wrap.
    lv_adj = 1; lv_sel = 0; step(0, 0, 0);
    for (int i = 0; i < 120 && m_min != MIN_MAX; i++) step(0, 0, 1);
    lv_sel = 1;
    for (int i = 0; i < 70 && m_sec != 58; i++) step(0, 0, 1);
    lv_adj = 0; step(0, 0, 0);
    press_pause();
    step(0, 1, 0); step(0, 0, 0);
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);

    // Seconds-field adjust wrapping 58 -> 59 -> 00 -> 01.
    lv_adj = 1; lv_sel = 1; step(0, 0, 0);
    for (int i = 0; i < 70 && m_sec != 58; i++) step(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      step(0, 0, 0);
    end
    lv_adj = 0; step(0, 0, 0);

    // Clear coinciding with a tick at 00:09 in RUN.
    lv_clear = 1; step(0, 0, 0);
    lv_clear = 0; step(0, 0, 0);
    press_pause();
    for (int i = 0; i < 9; i++) step(0, 1, 0);
    lv_clear = 1; step(0, 1, 0);
    lv_clear = 0; step(0, 0, 0);
    step(0, 1, 0); step(0, 0, 0);

    // Pause button held through reset gives no edge.
    lv_pause = 1;
    step(1, 0, 0); step(0, 0, 0);
    step(0, 1, 0); step(0, 0, 0);
    lv_pause = 0; step(0, 0, 0);
    press_pause();
    step(0, 1, 0); step(0, 1, 0); step(0, 0, 0);

`ifdef CLOCK_CORE_COUNTDOWN_EN
    // Countdown from 00:02 down through the underflow tick.
    lv_clear = 1; step(0, 0, 0);
    lv_clear = 0;
    lv_adj = 1; lv_sel = 1; step(0, 0, 0);
    step(0, 0, 1); step(0, 0, 1);
    lv_adj = 0; step(0, 0, 0);
    press_pause();
    lv_cd = 1;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      step(0, 0, 0);
    end
    step(0, 1, 0); step(0, 0, 0);
    lv_cd = 0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) lv_pause = !lv_pause;
      if ($urandom_range(59) == 0) lv_clear = !lv_clear;
      if ($urandom_range(149) == 0) lv_adj = !lv_adj;
      if ($urandom_range(30) == 0) lv_sel = !lv_sel;
`ifdef CLOCK_CORE_COUNTDOWN_EN
      if ($urandom_range(200) == 0) lv_cd = !lv_cd;
`endif
      step(($urandom_range(1999) == 0), ($urandom_range(3) == 0), ($urandom_range(2) == 0));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_core.md
Name: clock_core

Overview:
- Timekeeping core for the minutes:seconds clock. Holds four BCD digits (MM:SS), runs, pauses, clears and supports manual adjustment from debounced user inputs.
- Produces the digit, selection and blink signals consumed directly by the 7-segment display multiplexer.
- Timing comes from external single-cycle enable pulses, so all logic runs on one clock (clk).

Parameters:
- MIN_MAX, 99, highest minutes value before wrap to 00. Legal range 1..99.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-cycle enable pulse at 1 Hz (count rate)
- tick_2hz  in  1  one-cycle enable pulse at 2 Hz (adjust and blink rate)
- btn_pause  in  1  debounced level; each rising edge toggles run/pause
- btn_clear  in  1  debounced level; a rising edge clears the time
- sw_adj  in  1  level; 1 selects adjust mode
- sw_sel  in  1  level in adjust mode; 0 adjusts minutes, 1 adjusts seconds
- mt, mo, st, so  out  4 each  BCD digits: minutes tens/ones, seconds tens/ones
- blink_enable  out  1  1 while in ADJ
- blink_state  out  1  blink phase; display blanks the selected field when 0
- sel_minutes  out  1  ADJ && !sw_sel
- sel_seconds  out  1  ADJ && sw_sel
- rollover  out  1  one-cycle pulse when the time wraps MM_MAX:59 -> 00:00 in RUN

Behaviour:
- Reset (rst=1 at a clk edge):
  - All digits 0; state = PAUSE; rollover = 0; blink_state = 0.
  - Button edge-history registers set to 1, so a button held through reset produces no edge.
- Edge detect: edge = level & ~prev; prev is registered every cycle.
- FSM states: RUN, PAUSE, ADJ.
  - sw_adj=1 forces ADJ from any state on the next cycle.
  - In ADJ, sw_adj=0 returns to PAUSE.
  - In RUN or PAUSE, a pause edge toggles RUN<->PAUSE.
  - Pause edges in ADJ are ignored.
- RUN, on tick_1hz, increment with carry:
  - so 9->0 carries to st.
  - st 5->0 carries to mo.
  - mo 9->0 carries to mt.
  - At minutes == MIN_MAX with seconds 59, all digits go to 0 and rollover pulses for exactly that update cycle.
- PAUSE: digits hold; ticks ignored.
- ADJ, on tick_2hz, increment only the selected field, with no carry out:
  - Seconds 59 -> 00.
  - Minutes MIN_MAX -> 00.
  - rollover is never asserted in ADJ.
- sw_sel is sampled at the tick cycle.
- blink_state toggles on every tick_2hz in all states, giving a 1 Hz square wave. It is forced to 1 on the cycle the FSM enters ADJ, so the selected field is visible immediately.
- Clear edge sets all digits to 0 in any state. The state is unchanged.
- Latency: digits, rollover and state update on the clk edge at which the qualifying pulse or edge is sampled. Outputs are registered, except sel_minutes, sel_seconds and blink_enable, which are decoded from the state register and sw_sel.
- Simultaneous events:
  - Clear beats a tick in the same cycle: the result is 00:00, and rollover = 0.
  - A tick is evaluated against the current (pre-transition) state. A pause edge coinciding with tick_1hz in RUN still counts that tick, then moves to PAUSE.
  - sw_adj rising in the same cycle as tick_1hz in RUN: the tick counts; ADJ is entered on the next cycle.
- Digits never leave legal BCD ranges (so 0-9, st 0-5, mo/mt within MIN_MAX).

Optional Feature:
- Macro: CLOCK_CORE_COUNTDOWN_EN.
- When defined:
  - Adds input count_down (1 bit). In RUN with count_down=1, tick_1hz decrements with borrow.
  - At 00:00, a tick leaves the digits at 00:00, pulses rollover for one cycle, and moves the FSM to PAUSE.
  - ADJ field increments are unchanged.
- When undefined: the port is absent and the block counts up only.

Test Plan:
- Reset, then pulse btn_pause, then 75 tick_1hz -> state RUN, digits 01:15, rollover never asserted.
- Preload to 99:58 via ADJ (MIN_MAX=99), return to PAUSE, enter RUN, 2 ticks -> 99:59, then 00:00 with rollover high for exactly 1 cycle.
- sw_adj=1, sw_sel=1, seconds at 58, 3 tick_2hz -> seconds 59, 00, 01; minutes unchanged; sel_seconds=1; blink_enable=1; blink_state=1 on entry.
- Clear edge in the same cycle as tick_1hz at 00:09 in RUN -> 00:00, state stays RUN, rollover=0.
- Hold btn_pause=1 across rst deassert -> no toggle; release and press again -> RUN.
- With CLOCK_CORE_COUNTDOWN_EN, count_down=1, start at 00:02, 3 ticks -> 00:01, 00:00, then 00:00 with one rollover pulse and state PAUSE.
